muldiv_unit: RTL and testbench



---
 rtl/muldiv_unit.sv | 181 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, valid/ready on both ends.
// Define MULDIV_EARLY_OUT_EN to finish zero-operand ops in one cycle.
module muldiv_unit #(
   parameter int unsigned XLEN           = 32,
   parameter int unsigned BITS_PER_CYCLE = 1,
   parameter int unsigned TAG_W          = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       funct3,
   input  logic [XLEN-1:0]  a,
   input  logic [XLEN-1:0]  b,
   input  logic [TAG_W-1:0] tag_in,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  result,
   output logic [TAG_W-1:0] tag_out,
   output logic             busy
);

   localparam int unsigned Steps = XLEN / BITS_PER_CYCLE;
   localparam int unsigned CntW  = $clog2(Steps + 1);
   localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

   state_e stateQ, stateD;

   logic [CntW-1:0]  cntQ;
   logic [2:0]       opQ;
   logic [XLEN-1:0]  hiQ, loQ, magBQ, resultQ;
   logic [TAG_W-1:0] tagQ;
   logic             negAQ, negBQ;

   logic             accept;
   logic             isDiv, aSigned, bSigned, negA, negB;
   logic [XLEN-1:0]  magA, magB;
   logic             special;
   logic [XLEN-1:0]  specialRes;

   // Issue-side decode: operand magnitudes, sign flags and single-cycle special cases.
   always_comb begin
      isDiv   = funct3[2];
      aSigned = (funct3 != 3'b011) && (funct3 != 3'b101) && (funct3 != 3'b111);
      bSigned = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b100) ||
                (funct3 == 3'b110);
      negA    = aSigned & a[XLEN-1];
      negB    = bSigned & b[XLEN-1];
      magA    = negA ? -a : a;
      magB    = negB ? -b : b;

      special    = 1'b0;
      specialRes = '0;
      if (isDiv && (b == '0)) begin
         special    = 1'b1;
         specialRes = funct3[1] ? a : '1;
      end else if (isDiv && !funct3[0] && (a == MinNeg) && (b == '1)) begin
         special    = 1'b1;
         specialRes = funct3[1] ? '0 : a;
      end
`ifdef MULDIV_EARLY_OUT_EN
      else if (!isDiv && ((a == '0) || (b == '0))) begin
         special    = 1'b1;
         specialRes = '0;
      end else if (isDiv && (a == '0)) begin
         special    = 1'b1;
         specialRes = '0;
      end
`endif
   end

   assign accept = in_valid & (stateQ == StIdle) & ~flush;

   always_ff @(posedge clk) begin
      if (reset) stateQ <= StIdle;
      else       stateQ <= stateD;
   end

   always_comb begin
      stateD = stateQ;
      unique case (stateQ)
         StIdle:  if (in_valid) stateD = special ? StDone : StCalc;
         StCalc:  if (cntQ == CntW'(1)) stateD = StFix;
         StFix:   stateD = StDone;
         StDone:  if (out_ready) stateD = StIdle;
         default: stateD = StIdle;
      endcase
      if (flush) stateD = StIdle;
   end

   always_comb begin
      in_ready  = (stateQ == StIdle);
      busy      = (stateQ != StIdle);
      out_valid = (stateQ == StDone);
   end

   assign result  = resultQ;
   assign tag_out = tagQ;

   // hi/lo hold the running product (multiply) or remainder/quotient (divide).
   logic [XLEN:0]   mulSum, divRem;
   logic [XLEN-1:0] mulHi, mulLo, divHi, divLo;

   always_comb begin
      mulHi  = hiQ;
      mulLo  = loQ;
      mulSum = '0;
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
         mulSum = {1'b0, mulHi} + (mulLo[0] ? {1'b0, magBQ} : '0);
         mulLo  = {mulSum[0], mulLo[XLEN-1:1]};
         mulHi  = mulSum[XLEN:1];
      end
   end

   always_comb begin
      divHi  = hiQ;
      divLo  = loQ;
      divRem = '0;
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
         divRem = {divHi, divLo[XLEN-1]};
         divLo  = {divLo[XLEN-2:0], 1'b0};
         if (divRem >= {1'b0, magBQ}) begin
            divRem   = divRem - {1'b0, magBQ};
            divLo[0] = 1'b1;
         end
         divHi = divRem[XLEN-1:0];
      end
   end

   logic [2*XLEN-1:0] prod, prodS;
   logic [XLEN-1:0]   quoS, remS, fixRes;

   always_comb begin
      prod  = {hiQ, loQ};
      prodS = (negAQ ^ negBQ) ? -prod : prod;
      quoS  = (negAQ ^ negBQ) ? -loQ : loQ;
      remS  = negAQ ? -hiQ : hiQ;
      unique case (opQ)
         3'b000:                 fixRes = prodS[XLEN-1:0];
         3'b001, 3'b010, 3'b011: fixRes = prodS[2*XLEN-1:XLEN];
         3'b100, 3'b101:         fixRes = quoS;
         default:                fixRes = remS;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cntQ    <= '0;
         opQ     <= '0;
         hiQ     <= '0;
         loQ     <= '0;
         magBQ   <= '0;
         resultQ <= '0;
         tagQ    <= '0;
         negAQ   <= 1'b0;
         negBQ   <= 1'b0;
      end else begin
         if (accept) begin
            opQ   <= funct3;
            tagQ  <= tag_in;
            negAQ <= negA;
            negBQ <= negB;
            magBQ <= magB;
            hiQ   <= '0;
            loQ   <= magA;
            cntQ  <= CntW'(Steps);
            if (special) resultQ <= specialRes;
         end
         if (stateQ == StCalc) begin
            hiQ  <= opQ[2] ? divHi : mulHi;
            loQ  <= opQ[2] ? divLo : mulLo;
            cntQ <= cntQ - CntW'(1);
         end
         if ((stateQ == StFix) && !flush) resultQ <= fixRes;
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases, random ops against an arithmetic model,
// backpressure, flush, mid-op reset and back-to-back issue.
module tb_muldiv_unit;

   localparam int unsigned XLEN    = 32;
   localparam int unsigned BPC     = 1;
   localparam int unsigned TAG_W   = 5;
   localparam int          FullLat = XLEN / BPC + 2;

   logic             clk = 1'b0;
   logic             reset, in_valid, in_ready, flush, out_valid, out_ready, busy;
   logic [2:0]       funct3;
   logic [XLEN-1:0]  a, b, result;
   logic [TAG_W-1:0] tag_in, tag_out;

   int vectors = 0;
   int miscompares = 0;

   muldiv_unit #(.XLEN(XLEN), .BITS_PER_CYCLE(BPC), .TAG_W(TAG_W)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .funct3(funct3),
      .a(a), .b(b), .tag_in(tag_in), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .result(result), .tag_out(tag_out), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // RV32M semantics from plain 64-bit arithmetic.
   function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] x,
                                         input logic [31:0] y);
      longint      sx, sy, uy;
      int          qx, qy;
      logic [63:0] p;
      logic [31:0] r;
      logic        ovf;
      sx  = $signed(x);
      sy  = $signed(y);
      uy  = longint'({32'h0, y});
      qx  = $signed(x);
      qy  = $signed(y);
      ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
      p   = '0;
      r   = '0;
      case (f)
         3'd0: begin p = 64'(sx * sy); r = p[31:0]; end
         3'd1: begin p = 64'(sx * sy); r = p[63:32]; end
         3'd2: begin p = 64'(sx * uy); r = p[63:32]; end
         3'd3: begin p = {32'h0, x} * {32'h0, y}; r = p[63:32]; end
         3'd4: r = (y == 0) ? 32'hFFFF_FFFF : ovf ? x : 32'(qx / qy);
         3'd5: r = (y == 0) ? 32'hFFFF_FFFF : x / y;
         3'd6: r = (y == 0) ? x : ovf ? 32'h0 : 32'(qx % qy);
         default: r = (y == 0) ? x : x % y;
      endcase
      return r;
   endfunction

   function automatic int exp_lat(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
      if (f[2] && (y == 0)) return 1;
      if ((f == 3'd4 || f == 3'd6) && (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF)) return 1;
`ifdef MULDIV_EARLY_OUT_EN
      if (!f[2] && (x == 0 || y == 0)) return 1;
      if (f[2] && (x == 0)) return 1;
`endif
      return FullLat;
   endfunction

   // Issue one op from IDLE, scramble inputs after acceptance, wait for out_valid.
   // lat counts the accepting edge as 1. Pops the result unless hold is set.
   task automatic issue_op(input logic [2:0] f, input logic [31:0] av, input logic [31:0] bv,
                           input logic [4:0] t, input bit hold, output logic [31:0] r,
                           output logic [4:0] to, output int lat);
      funct3 = f; a = av; b = bv; tag_in = t; in_valid = 1'b1; out_ready = !hold;
      @(posedge clk); #1;
      in_valid = 1'b0;
      funct3 = 3'($urandom); a = $urandom; b = $urandom; tag_in = 5'($urandom);
      lat = 1;
      while (out_valid !== 1'b1 && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      r  = result;
      to = tag_out;
      if (!hold) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; funct3 = '0; a = '0; b = '0; tag_in = '0;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if ({in_ready, out_valid, busy} !== 3'b100) begin
         miscompares++;
         $display("FAIL reset_ctrl: in_ready/out_valid/busy=%b want 100",
                  {in_ready, out_valid, busy});
      end
      vectors++;
      if (result !== '0 || tag_out !== '0) begin
         miscompares++;
         $display("FAIL reset_data: result=%h tag_out=%h want 0/0", result, tag_out);
      end
      reset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_directed();
      logic [2:0]  df [12];
      logic [31:0] da [12], db [12], dr [12];
      logic [31:0] r;
      logic [4:0]  to;
      int          lat;
      df = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd7, 3'd4, 3'd6};
      da = '{32'd7, 32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
             32'd100, 32'd100, 32'd13, 32'd13, 32'h8000_0000, 32'h8000_0000};
      db = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h8000_0000, 32'd2, 32'd2, 32'd2,
             32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      dr = '{32'hFFFF_FFEB, 32'h6, 32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
             32'd14, 32'd2, 32'hFFFF_FFFF, 32'd13, 32'h8000_0000, 32'd0};
      for (int i = 0; i < 12; i++) begin
         issue_op(df[i], da[i], db[i], (i == 0) ? 5'd5 : 5'(i), 1'b0, r, to, lat);
         vectors++;
         if (r !== dr[i]) begin
            miscompares++;
            $display("FAIL directed_%0d result: got %h want %h", i, r, dr[i]);
         end
         vectors++;
         if (to !== ((i == 0) ? 5'd5 : 5'(i))) begin
            miscompares++;
            $display("FAIL directed_%0d tag: got %0d want %0d", i, to, (i == 0) ? 5 : i);
         end
         vectors++;
         if (lat != exp_lat(df[i], da[i], db[i])) begin
            miscompares++;
            $display("FAIL directed_%0d latency: got %0d want %0d", i, lat,
                     exp_lat(df[i], da[i], db[i]));
         end
      end
   endtask

   function automatic logic [31:0] pick_operand();
      logic [31:0] corner [5];
      corner = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
      if ($urandom_range(3) == 0) return corner[$urandom_range(4)];
      return $urandom;
   endfunction

   task automatic test_random();
      logic [2:0]  f;
      logic [31:0] x, y, r;
      logic [4:0]  t, to;
      int          lat;
      for (int i = 0; i < 48; i++) begin
         f = 3'($urandom); x = pick_operand(); y = pick_operand(); t = 5'($urandom);
         issue_op(f, x, y, t, 1'b0, r, to, lat);
         vectors++;
         if (r !== model(f, x, y) || to !== t || lat != exp_lat(f, x, y)) begin
            miscompares++;
            $display("FAIL random_%0d f3=%0d a=%h b=%h: result/tag/lat=%h/%0d/%0d want %h/%0d/%0d",
                     i, f, x, y, r, to, lat, model(f, x, y), t, exp_lat(f, x, y));
         end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] x, y, r;
      logic [4:0]  to;
      int          lat;
      x = $urandom; y = $urandom;
      issue_op(3'd1, x, y, 5'd9, 1'b1, r, to, lat);
      vectors++;
      if (r !== model(3'd1, x, y) || to !== 5'd9) begin
         miscompares++;
         $display("FAIL bp_result: got %h/%0d want %h/9", r, to, model(3'd1, x, y));
      end
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         vectors++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== r || tag_out !== 5'd9) begin
            miscompares++;
            $display("FAIL bp_hold_%0d: valid/ready/result/tag=%b/%b/%h/%0d want 1/0/%h/9",
                     i, out_valid, in_ready, result, tag_out, r);
         end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL bp_release: out_valid/in_ready=%b/%b want 0/1", out_valid, in_ready);
      end
   endtask

   task automatic test_flush();
      logic [31:0] r;
      logic [4:0]  to;
      int          lat, seen;
      funct3 = 3'd0; a = 32'd11; b = 32'd13; tag_in = 5'd3; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      vectors++;
      if (busy !== 1'b1) begin
         miscompares++;
         $display("FAIL flush_precond: busy=%b want 1", busy);
      end
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      vectors++;
      if ({in_ready, busy, out_valid} !== 3'b100) begin
         miscompares++;
         $display("FAIL flush_calc: in_ready/busy/out_valid=%b want 100",
                  {in_ready, busy, out_valid});
      end
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (out_valid === 1'b1) seen++;
      end
      vectors++;
      if (seen != 0) begin
         miscompares++;
         $display("FAIL flush_no_result: out_valid seen %0d cycles want 0", seen);
      end
      in_valid = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; flush = 1'b0;
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL flush_issue: busy=%b want 0", busy);
      end
      issue_op(3'd5, 32'd50, 32'd5, 5'd4, 1'b1, r, to, lat);
      flush = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL flush_done: out_valid/in_ready=%b/%b want 0/1", out_valid, in_ready);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] r;
      logic [4:0]  to;
      int          lat;
      funct3 = 3'd4; a = 32'd1000; b = 32'd3; tag_in = 5'd17; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (15) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      vectors++;
      if ({in_ready, out_valid, busy} !== 3'b100 || result !== '0 || tag_out !== '0) begin
         miscompares++;
         $display("FAIL reset_mid: ready/valid/busy=%b result=%h tag=%0d want 100/0/0",
                  {in_ready, out_valid, busy}, result, tag_out);
      end
      issue_op(3'd0, 32'd3, 32'd4, 5'd2, 1'b0, r, to, lat);
      vectors++;
      if (r !== 32'd12 || to !== 5'd2 || lat != FullLat) begin
         miscompares++;
         $display("FAIL reset_followup: result/tag/lat=%h/%0d/%0d want c/2/%0d", r, to, lat,
                  FullLat);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] r;
      logic [4:0]  to;
      int          lat;
      issue_op(3'd7, 32'd29, 32'd5, 5'd8, 1'b1, r, to, lat);
      funct3 = 3'd0; a = 32'd5; b = 32'd6; tag_in = 5'd21; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      vectors++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_no_reaccept: out_valid/busy=%b/%b want 0/0", out_valid, busy);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      vectors++;
      if (busy !== 1'b1) begin
         miscompares++;
         $display("FAIL b2b_accept: busy=%b want 1", busy);
      end
      lat = 1;
      while (out_valid !== 1'b1 && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      vectors++;
      if (result !== 32'd30 || tag_out !== 5'd21 || lat != FullLat) begin
         miscompares++;
         $display("FAIL b2b_result: result/tag/lat=%h/%0d/%0d want 1e/21/%0d", result, tag_out,
                  lat, FullLat);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_backpressure();
      test_flush();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
